// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem valid/ready requests and the IF/ID register.
// Optional misaligned-fetch fault detection is enabled by defining IF_MISALIGN_CHECK_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_inst,
   output logic        ifid_misalign
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]  state_r, state_s;
   logic [31:0] pc_r, pc_s;
   logic [31:0] redir_r, redir_s;
   logic [31:0] buf_r, buf_s;
   logic        buf_mis_r, buf_mis_s;
   logic        ifid_valid_r, ifid_valid_s;
   logic [31:0] ifid_pc_r, ifid_pc_s;
   logic [31:0] ifid_inst_r, ifid_inst_s;
   logic        ifid_mis_r, ifid_mis_s;
   logic        mis_s;
   logic        resp_s;
   logic [31:0] word_s;
   logic        load_s;
   logic [31:0] ld_inst_s;
   logic        ld_mis_s;

`ifdef IF_MISALIGN_CHECK_EN
   assign mis_s = (state_r == S_FETCH) && (pc_r[1:0] != 2'b00);
`else
   assign mis_s = 1'b0;
`endif

   // A misaligned fetch behaves like an immediate response carrying a NOP.
   assign resp_s    = (state_r == S_FETCH) && (mis_s || imem_ready);
   assign word_s    = mis_s ? NOP_INST : imem_rdata;
   assign imem_req  = !rst && (((state_r == S_FETCH) && !mis_s) || (state_r == S_DRAIN));
   assign imem_addr = {pc_r[31:2], 2'b00};

   assign pc            = pc_r;
   assign ifid_valid    = ifid_valid_r;
   assign ifid_pc       = ifid_pc_r;
   assign ifid_inst     = ifid_inst_r;
   assign ifid_misalign = ifid_mis_r;

   // Fetch control: next state, PC, redirect target and stall buffer.
   always_comb begin
      state_s   = state_r;
      pc_s      = pc_r;
      redir_s   = redir_r;
      buf_s     = buf_r;
      buf_mis_s = buf_mis_r;
      load_s    = 1'b0;
      ld_inst_s = buf_r;
      ld_mis_s  = buf_mis_r;
      case (state_r)
         S_FETCH: begin
            if (flush) begin
               if (resp_s) begin
                  pc_s = npc;
               end else begin
                  redir_s = npc;
                  state_s = S_DRAIN;
               end
            end else if (resp_s) begin
               if (stall) begin
                  buf_s     = word_s;
                  buf_mis_s = mis_s;
                  state_s   = S_HOLD;
               end else begin
                  load_s    = 1'b1;
                  ld_inst_s = word_s;
                  ld_mis_s  = mis_s;
                  pc_s      = npc;
               end
            end else begin
               state_s = S_FETCH;
            end
         end
         S_HOLD: begin
            if (flush) begin
               pc_s    = npc;
               state_s = S_FETCH;
            end else if (!stall) begin
               load_s  = 1'b1;
               pc_s    = npc;
               state_s = S_FETCH;
            end else begin
               state_s = S_HOLD;
            end
         end
         S_DRAIN: begin
            // A flush coinciding with the wrong-path response redirects straight to npc.
            if (imem_ready) begin
               pc_s    = flush ? npc : redir_r;
               state_s = S_FETCH;
            end else if (flush) begin
               redir_s = npc;
            end else begin
               redir_s = redir_r;
            end
         end
         default: begin
            state_s = S_FETCH;
         end
      endcase
   end

   // IF/ID update with priority flush > stall > load > bubble.
   always_comb begin
      ifid_valid_s = ifid_valid_r;
      ifid_pc_s    = ifid_pc_r;
      ifid_inst_s  = ifid_inst_r;
      ifid_mis_s   = ifid_mis_r;
      if (flush) begin
         ifid_valid_s = 1'b0;
         ifid_inst_s  = NOP_INST;
         ifid_mis_s   = 1'b0;
      end else if (stall) begin
         ifid_valid_s = ifid_valid_r;
      end else if (load_s) begin
         ifid_valid_s = 1'b1;
         ifid_pc_s    = pc_r;
         ifid_inst_s  = ld_inst_s;
         ifid_mis_s   = ld_mis_s;
      end else begin
         ifid_valid_s = 1'b0;
         ifid_inst_s  = NOP_INST;
         ifid_mis_s   = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_FETCH;
         pc_r         <= RESET_PC;
         redir_r      <= 32'h0000_0000;
         buf_r        <= NOP_INST;
         buf_mis_r    <= 1'b0;
         ifid_valid_r <= 1'b0;
         ifid_pc_r    <= 32'h0000_0000;
         ifid_inst_r  <= NOP_INST;
         ifid_mis_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         pc_r         <= pc_s;
         redir_r      <= redir_s;
         buf_r        <= buf_s;
         buf_mis_r    <= buf_mis_s;
         ifid_valid_r <= ifid_valid_s;
         ifid_pc_r    <= ifid_pc_s;
         ifid_inst_r  <= ifid_inst_s;
         ifid_mis_r   <= ifid_mis_s;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, corner sequences, then random traffic
// checked against a flag-based behavioural model of the fetch stage.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] tgt = 32'h0;
   logic [31:0] npc, pc, imem_addr, ifid_pc, ifid_inst;
   logic        imem_req, ifid_valid, ifid_misalign;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   // next-PC logic: sequential unless redirected
   assign npc = flush ? tgt : pc + 32'd4;

   if_stage dut (
      .clk(clk), .rst(rst), .npc(npc), .stall(stall), .flush(flush), .pc(pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
      .ifid_inst(ifid_inst), .ifid_misalign(ifid_misalign)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return ~a ^ 32'h5A00_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        st, fl, rd;
      logic [31:0] tg;
      logic        req;
      logic [31:0] addr;
      logic        v;
      logic [31:0] ipc, inst;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic st, input logic fl, input logic [31:0] tg, input logic rd,
                      input logic req, input logic [31:0] addr,
                      input logic v, input logic [31:0] ipc, input logic [31:0] inst);
      vec_t r;
      r.st = st; r.fl = fl; r.tg = tg; r.rd = rd; r.req = req; r.addr = addr;
      r.v = v; r.ipc = ipc; r.inst = inst;
      tbl.push_back(r);
   endtask

   // Apply inputs mid-cycle; memory returns the word at the current address.
   task automatic drive(input logic st, input logic fl, input logic [31:0] tg, input logic rd);
      @(negedge clk);
      stall = st; flush = fl; tgt = tg; imem_ready = rd;
      #1;
      imem_rdata = word_of(imem_addr);
      #1;
   endtask

   task automatic post_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b1;
      #1;
      chk("req_in_reset", {31'b0, imem_req}, 32'h0);
      post_edge();
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_ifid_pc", ifid_pc, 32'h0);
      chk("rst_inst", ifid_inst, NOP);
      chk("rst_misalign", {31'b0, ifid_misalign}, 32'h0);
      rst = 1'b0; imem_ready = 1'b0;
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc, m_redir, m_buf;
   logic        m_wrong, m_held, m_bufmis;
   logic        e_v, e_mis;
   logic [31:0] e_pc, e_inst;

   task automatic m_reset();
      m_pc = 32'h0; m_redir = 32'h0; m_buf = NOP; m_wrong = 1'b0; m_held = 1'b0;
      m_bufmis = 1'b0; e_v = 1'b0; e_pc = 32'h0; e_inst = NOP; e_mis = 1'b0;
   endtask

   function automatic logic m_misaligned();
      return MIS_EN && !m_held && !m_wrong && (m_pc[1:0] != 2'b00);
   endfunction

   task automatic m_kill();
      e_v = 1'b0; e_inst = NOP; e_mis = 1'b0;
   endtask

   task automatic m_load(input logic [31:0] a, input logic [31:0] w, input logic mis);
      e_v = 1'b1; e_pc = a; e_inst = w; e_mis = mis;
   endtask

   task automatic m_step(input logic st, input logic fl, input logic [31:0] tg, input logic rd);
      logic        mis, take;
      logic [31:0] w;
      mis  = m_misaligned();
      w    = mis ? NOP : word_of({m_pc[31:2], 2'b00});
      take = rd || mis;
      if (m_held) begin
         if (fl) begin m_held = 1'b0; m_pc = tg; m_kill(); end
         else if (!st) begin m_load(m_pc, m_buf, m_bufmis); m_pc = m_pc + 32'd4; m_held = 1'b0; end
      end else if (m_wrong) begin
         if (rd) begin m_pc = fl ? tg : m_redir; m_wrong = 1'b0; end
         else if (fl) m_redir = tg;
         if (fl || !st) m_kill();
      end else begin
         if (fl) begin
            if (take) m_pc = tg;
            else begin m_wrong = 1'b1; m_redir = tg; end
            m_kill();
         end else if (take) begin
            if (st) begin m_held = 1'b1; m_buf = w; m_bufmis = mis; end
            else begin m_load(m_pc, w, mis); m_pc = m_pc + 32'd4; end
         end else if (!st) m_kill();
      end
   endtask

   initial begin
      logic        st, fl, rd, ereq;
      logic [31:0] tg;

      do_reset();

      // Directed table: zero-wait, delayed ready, stall, flush/drain, wrap, double flush.
      add(0,0,0,1, 1,32'h00, 1,32'h00,word_of(32'h00));
      add(0,0,0,1, 1,32'h04, 1,32'h04,word_of(32'h04));
      add(0,0,0,1, 1,32'h08, 1,32'h08,word_of(32'h08));
      add(0,0,0,1, 1,32'h0C, 1,32'h0C,word_of(32'h0C));
      add(0,0,0,0, 1,32'h10, 0,32'h0C,NOP);
      add(0,0,0,0, 1,32'h10, 0,32'h0C,NOP);
      add(0,0,0,0, 1,32'h10, 0,32'h0C,NOP);
      add(0,0,0,1, 1,32'h10, 1,32'h10,word_of(32'h10));
      add(0,0,0,1, 1,32'h14, 1,32'h14,word_of(32'h14));
      add(0,0,0,1, 1,32'h18, 1,32'h18,word_of(32'h18));
      add(0,0,0,1, 1,32'h1C, 1,32'h1C,word_of(32'h1C));
      add(1,0,0,1, 1,32'h20, 1,32'h1C,word_of(32'h1C));
      add(1,0,0,0, 0,32'h20, 1,32'h1C,word_of(32'h1C));
      add(0,0,0,0, 0,32'h20, 1,32'h20,word_of(32'h20));
      add(0,0,0,1, 1,32'h24, 1,32'h24,word_of(32'h24));
      add(0,0,0,1, 1,32'h28, 1,32'h28,word_of(32'h28));
      add(0,0,0,1, 1,32'h2C, 1,32'h2C,word_of(32'h2C));
      add(0,0,0,0, 1,32'h30, 0,32'h2C,NOP);
      add(0,1,32'h100,0, 1,32'h30, 0,32'h2C,NOP);
      add(0,0,0,1, 1,32'h30, 0,32'h2C,NOP);
      add(0,0,0,1, 1,32'h100, 1,32'h100,word_of(32'h100));
      add(1,1,32'h200,1, 1,32'h104, 0,32'h100,NOP);
      add(0,0,0,1, 1,32'h200, 1,32'h200,word_of(32'h200));
      add(0,1,32'hFFFF_FFFC,1, 1,32'h204, 0,32'h200,NOP);
      add(0,0,0,1, 1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,word_of(32'hFFFF_FFFC));
      add(0,0,0,1, 1,32'h0, 1,32'h0,word_of(32'h0));
      add(0,0,0,0, 1,32'h4, 0,32'h0,NOP);
      add(0,1,32'h300,0, 1,32'h4, 0,32'h0,NOP);
      add(0,1,32'h400,0, 1,32'h4, 0,32'h0,NOP);
      add(0,0,0,1, 1,32'h4, 0,32'h0,NOP);
      add(0,0,0,1, 1,32'h400, 1,32'h400,word_of(32'h400));

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].fl, tbl[i].tg, tbl[i].rd);
         chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
         chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
         post_edge();
         chk($sformatf("t%0d_valid", i), {31'b0, ifid_valid}, {31'b0, tbl[i].v});
         chk($sformatf("t%0d_ifid_pc", i), ifid_pc, tbl[i].ipc);
         chk($sformatf("t%0d_inst", i), ifid_inst, tbl[i].inst);
      end

      // Redirect to a misaligned PC, then fetch there.
      drive(1'b0, 1'b1, 32'h42, 1'b1);
      post_edge();
      chk("mis_flush_valid", {31'b0, ifid_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IF_MISALIGN_CHECK_EN
      chk("mis_req", {31'b0, imem_req}, 32'h0);
      post_edge();
      chk("mis_inst", ifid_inst, NOP);
      chk("mis_flag", {31'b0, ifid_misalign}, 32'h1);
`else
      chk("mis_addr", imem_addr, 32'h40);
      post_edge();
      chk("mis_inst", ifid_inst, word_of(32'h40));
      chk("mis_flag", {31'b0, ifid_misalign}, 32'h0);
`endif
      chk("mis_valid", {31'b0, ifid_valid}, 32'h1);
      chk("mis_ifid_pc", ifid_pc, 32'h42);

      // Random traffic against the model, with a reset dropped in mid-run.
      do_reset();
      m_reset();
      for (int c = 0; c < 600; c++) begin
         if (c == 300) begin
            do_reset();
            m_reset();
         end
         st = ($urandom_range(0, 9) < 3);
         fl = ($urandom_range(0, 9) == 0);
         rd = ($urandom_range(0, 9) < 6);
         tg = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
         drive(st, fl, tg, rd);
         ereq = !m_held && !m_misaligned();
         chk($sformatf("r%0d_req", c), {31'b0, imem_req}, {31'b0, ereq});
         chk($sformatf("r%0d_addr", c), imem_addr, {m_pc[31:2], 2'b00});
         m_step(st, fl, tg, rd);
         post_edge();
         chk($sformatf("r%0d_pc", c), pc, m_pc);
         chk($sformatf("r%0d_valid", c), {31'b0, ifid_valid}, {31'b0, e_v});
         chk($sformatf("r%0d_ifid_pc", c), ifid_pc, e_pc);
         chk($sformatf("r%0d_inst", c), ifid_inst, e_inst);
         chk($sformatf("r%0d_mis", c), {31'b0, ifid_misalign}, {31'b0, e_mis});
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined RV32 CPU. Holds the architectural fetch PC, drives it to the next-PC logic, issues instruction-memory reads with a valid/ready handshake, and owns the IF/ID pipeline register. Sits directly upstream of the next-PC logic, which consumes `pc` and returns `npc`, and upstream of decode. Absorbs variable memory latency, ID-stage stalls, and branch/jump flushes.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INST, 32'h0000_0013, instruction loaded into IF/ID for bubbles (addi x0,x0,0)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- npc  in  32  next PC from next-PC logic, combinational on `pc`
- stall  in  1  hazard unit: ID cannot accept; IF/ID holds
- flush  in  1  redirect: current fetch and IF/ID contents are wrong-path; `npc` carries target this cycle
- pc  out  32  current fetch PC
- imem_req  out  1  read request
- imem_addr  out  32  read address = {pc[31:2],2'b00}
- imem_ready  in  1  read data valid this cycle; completes request
- imem_rdata  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of IF/ID instruction
- ifid_inst  out  32  IF/ID instruction
- ifid_misalign  out  1  IF/ID entry is a misaligned-fetch fault (see Configuration)

## Operation
- States: S_FETCH (request outstanding), S_HOLD (word buffered, ID stalled), S_DRAIN (wrong-path request outstanding).
- imem_req = !rst && state∈{S_FETCH,S_DRAIN}. Address stays stable while req=1 and ready=0.
- S_FETCH, ready=0: no change. If flush: redir_pc<=npc, IF/ID valid<=0, go S_DRAIN.
- S_FETCH, ready=1, flush=1: response discarded, pc<=npc, ifid_valid<=0, stay.
- S_FETCH, ready=1, stall=0: IF/ID<={1,pc,imem_rdata}, pc<=npc.
- S_FETCH, ready=1, stall=1: buf<=imem_rdata, IF/ID held, go S_HOLD.
- S_HOLD: req=0. flush: buffer dropped, pc<=npc, ifid_valid<=0, go S_FETCH. Else stall=0: IF/ID<={1,pc,buf}, pc<=npc, go S_FETCH. Else hold.
- S_DRAIN: on ready, data discarded, pc<=redir_pc, go S_FETCH. A second flush in S_DRAIN overwrites redir_pc with npc.
- IF/ID priority: flush > stall > load > bubble. Bubble (no load, stall=0) sets valid=0, inst=NOP_INST, pc unchanged.
- PC arithmetic is 32-bit wrap; 32'hFFFF_FFFC+4 = 0, no special case.

## Timing
- Reset values: pc=RESET_PC, state=S_FETCH, ifid_valid=0, ifid_pc=0, ifid_inst=NOP_INST, ifid_misalign=0, imem_req=0 during rst.
- Zero-wait memory (ready same cycle as req): one instruction per cycle; IF/ID updated on the edge after ready.
- Latency: imem_ready at cycle N → ifid_valid/inst visible cycle N+1.
- rst mid-request overrides all; outstanding memory response after reset is not tracked (memory is reset together).

## Configuration
- IF_MISALIGN_CHECK_EN defined: in S_FETCH, pc[1:0]!=0 suppresses imem_req; next edge (subject to stall/flush rules as a ready=1 response) loads IF/ID with valid=1, inst=NOP_INST, ifid_misalign=1, pc<=npc.
- Undefined: pc[1:0] ignored, address aligned by truncation, ifid_misalign tied 0.

## Test plan
- Reset, zero-wait memory, npc=pc+4: IF/ID pc sequence 0,4,8,C on consecutive cycles, valid=1.
- ready delayed 3 cycles at pc=0x10: imem_addr stable 0x10 for 4 cycles, ifid_valid=0 bubbles, then ifid_inst=rdata, ifid_pc=0x10.
- stall=1 for 2 cycles when word at 0x20 arrives: IF/ID holds prior entry, req=0 in S_HOLD; stall drop → ifid_pc=0x20, word from buffer.
- flush with npc=0x100 while request to 0x30 outstanding: ifid_valid=0; late response dropped; next request addr=0x100.
- flush and stall same cycle: ifid_valid=0 next cycle (flush wins).
- With IF_MISALIGN_CHECK_EN, pc=0x42: no imem_req; ifid_misalign=1, ifid_inst=0x00000013, ifid_pc=0x42.
